// File: rtl/vscale_dmem_responder.sv
// Data-memory responder for the vscale core. It owns a word-organised SRAM,
// accepts one request per cycle, and completes that request in a later data
// phase. The data phase can be delayed by a fixed number of wait states.
// Bad accesses are reported on dmem_badmem_e in the completing cycle.
module vscale_dmem_responder #(
  parameter int          ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_en,
  input  logic        dmem_wen,
  input  logic [2:0]  dmem_size,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata_delayed,
  output logic        dmem_wait,
  output logic [31:0] dmem_rdata,
  output logic        dmem_badmem_e
);

  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;
  localparam logic [3:0] WC    = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

  typedef struct packed {
    logic        wen;
    logic [2:0]  size;
    logic [31:0] addr;
  } req_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  req_t                pend;
  logic                accept;
  logic                in_data;
  logic [29:0]         off_w;
  logic [ADDR_BITS-1:0] widx;
  logic                oor, err, do_write;
  logic [31:0]         rword, wword;
  logic [7:0]          rbyte;
  logic [15:0]         rhalf;
  logic [3:0]          be;

  logic [31:0] mem [2**ADDR_BITS];

  assign dmem_wait = (state == S_WAIT);
  assign in_data   = (state == S_DATA);
  assign accept    = dmem_en && !dmem_wait;

  // Next state: acceptance is legal from IDLE and from DATA (pipelined).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE, S_DATA: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_nxt = S_DATA;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WC;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) begin
          state_nxt = S_DATA;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, wait counter and the request captured at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      pend  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) pend <= '{wen: dmem_wen, size: dmem_size, addr: dmem_addr};
    end
  end

  // Word offset from the base. BASE_ADDR is size-aligned, so any bit set
  // above the index range means the access falls outside the array.
  assign off_w = pend.addr[31:2] - BASE_ADDR[31:2];
  assign widx  = off_w[ADDR_BITS-1:0];
  assign oor   = |off_w[29:ADDR_BITS];

  // Error decode: unsupported sizes, misalignment and range.
  always_comb begin
    err = oor;
    case (pend.size)
      SZ_B, SZ_BU:  ;
      SZ_H, SZ_HU:  if (pend.addr[0]) err = 1'b1;
      SZ_W:         if (pend.addr[1:0] != 2'b00) err = 1'b1;
      default:      err = 1'b1;
    endcase
  end

  assign rword = mem[widx];
  assign rhalf = pend.addr[1] ? rword[31:16] : rword[15:0];

  // Byte lane pick for loads.
  always_comb begin
    case (pend.addr[1:0])
      2'd0:    rbyte = rword[7:0];
      2'd1:    rbyte = rword[15:8];
      2'd2:    rbyte = rword[23:16];
      default: rbyte = rword[31:24];
    endcase
  end

  // Load data: right-aligned and extended; zero unless a good load completes.
  always_comb begin
    dmem_rdata = '0;
    if (in_data && !pend.wen && !err) begin
      case (pend.size)
        SZ_B:    dmem_rdata = {{24{rbyte[7]}}, rbyte};
        SZ_BU:   dmem_rdata = {24'd0, rbyte};
        SZ_H:    dmem_rdata = {{16{rhalf[15]}}, rhalf};
        SZ_HU:   dmem_rdata = {16'd0, rhalf};
        default: dmem_rdata = rword;
      endcase
    end
  end

  assign dmem_badmem_e = in_data && err;

  // Store lane replication and byte enables.
  always_comb begin
    case (pend.size[1:0])
      2'd0: begin
        wword = {4{dmem_wdata_delayed[7:0]}};
        be    = 4'b0001 << pend.addr[1:0];
      end
      2'd1: begin
        wword = {2{dmem_wdata_delayed[15:0]}};
        be    = pend.addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wword = dmem_wdata_delayed;
        be    = 4'b1111;
      end
    endcase
  end

  // A store that is caught by reset is dropped.
  assign do_write = in_data && pend.wen && !err && !reset;

  // Array write at the edge that ends the data phase; contents are never reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

endmodule
